// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg -- shared CPU types for the fetch queue and its storage.
// Revision: 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } fq_state_t;

  typedef struct packed {
    word_t imemload;
    word_t npc;
  } fq_entry_t;

  localparam word_t INSTR_BYTES = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// fetch_queue_mem -- DEPTH-entry instruction storage, one synchronous write
// port and one asynchronous read port.
// Revision: 1.0
// ============================================================================
import cpu_types_pkg::*;

module fetch_queue_mem #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue -- instruction fetch unit with a DEPTH-entry decoupling queue.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards imemload to the head when empty.
// Revision: 1.0
// ============================================================================
import cpu_types_pkg::*;

module fetch_queue #(
  parameter int    DEPTH   = 4,
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     ihit,
  input  logic [31:0]              imemload,
  input  logic                     mem_busy,
  input  logic                     halt,
  input  logic                     flush,
  input  logic [31:0]              redirect_pc,
  input  logic                     deq,
  output logic                     imemREN,
  output logic [31:0]              imemaddr,
  output logic                     valid_out,
  output logic [31:0]              instr_out,
  output logic [31:0]              npc_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW         = $clog2(DEPTH);
  localparam int             CW         = PW + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  fq_state_t     state;
  fq_state_t     next_state;
  word_t         pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occ;
  fq_entry_t     head_entry;
  fq_entry_t     new_entry;

  logic deq_ok;
  logic enq_ok;
  logic bypass;
  logic bypass_consume;
  logic wr;

  assign deq_ok = deq && (occ != '0) && !flush;
  assign enq_ok = imemREN && ihit && ((occ != FULL_COUNT) || deq_ok);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass         = enq_ok && (occ == '0);
  assign bypass_consume = bypass && deq;
`else
  assign bypass         = 1'b0;
  assign bypass_consume = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never reaches storage.
  assign wr        = enq_ok && !bypass_consume;
  assign new_entry = '{imemload: imemload, npc: pc + INSTR_BYTES};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if ((occ == FULL_COUNT) && !deq && !flush) next_state = FULL;
      FULL:    if (deq || flush) next_state = FETCH;
      HALTED:  next_state = HALTED;
      default: next_state = FETCH;
    endcase
    if (halt) begin
      next_state = HALTED;
    end
  end

  always_comb begin
    imemREN = (state == FETCH) && !mem_busy && !flush && !halt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc   <= PC_INIT;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      // Halt freezes the fetch PC even against a redirect.
      if ((state != HALTED) && !halt) begin
        if (flush) begin
          pc <= redirect_pc;
        end else if (enq_ok) begin
          pc <= pc + INSTR_BYTES;
        end
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (wr)     tail <= tail + 1'b1;
        if (deq_ok) head <= head + 1'b1;
        occ <= occ + CW'(wr) - CW'(deq_ok);
      end
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .we    (wr),
    .waddr (tail),
    .wdata (new_entry),
    .raddr (head),
    .rdata (head_entry)
  );

  always_comb begin
    valid_out = (occ != '0);
    instr_out = '0;
    npc_out   = '0;
    if (occ != '0) begin
      instr_out = head_entry.imemload;
      npc_out   = head_entry.npc;
    end else if (bypass) begin
      valid_out = 1'b1;
      instr_out = imemload;
      npc_out   = new_entry.npc;
    end
  end

  assign imemaddr = pc;
  assign count    = occ;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue -- randomized scoreboard bench for fetch_queue (default build).
// Revision: 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        mem_busy = 1'b0;
  logic        halt = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        deq = 1'b0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic [2:0]  count;

  always #5 CLK = ~CLK;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_INIT (PC_INIT)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .mem_busy    (mem_busy),
    .halt        (halt),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .valid_out   (valid_out),
    .instr_out   (instr_out),
    .npc_out     (npc_out),
    .count       (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the queue contents in order, {instr, npc} per entry.
  logic [63:0] sb [$];
  logic [63:0] mon_e;
  logic [31:0] m_pc = PC_INIT;
  bit          m_full = 1'b0;
  bit          m_halted = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Head consumption: every accepted dequeue must present the oldest entry.
  always begin
    @(negedge CLK);
    #3;
    if (nRST && valid_out && deq && !flush) begin
      if (sb.size() == 0) begin
        check("deq_without_expected", 32'(valid_out), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("head_instr", instr_out, mon_e[63:32]);
        check("head_npc", npc_out, mon_e[31:0]);
      end
    end
  end

  task automatic step(input bit f, input logic [31:0] rpc, input bit h, input bit mb,
                      input bit ih, input logic [31:0] ld, input bit dq);
    int sz;
    bit ren, deq_eff, enq, was_halted;
    @(negedge CLK);
    #1;
    flush = f; redirect_pc = rpc; halt = h; mem_busy = mb;
    ihit = ih; imemload = ld; deq = dq;
    #1;
    sz  = sb.size();
    ren = !m_halted && !m_full && !mb && !f && !h;
    check("imemREN", 32'(imemREN), 32'(ren));
    check("imemaddr", imemaddr, m_pc);
    check("count", 32'(count), 32'(sz));
    check("valid_out", 32'(valid_out), 32'(sz != 0));
    deq_eff = dq && (sz > 0) && !f;
    enq     = ren && ih && ((sz < DEPTH) || deq_eff);
    #2;
    if (f) sb.delete();
    else if (enq) sb.push_back({ld, m_pc + 32'd4});
    was_halted = m_halted || h;
    if (!was_halted) begin
      if (f) m_pc = rpc;
      else if (enq) m_pc = m_pc + 32'd4;
    end
    if (was_halted) m_halted = 1'b1;
    else if (m_full) begin
      if (dq || f) m_full = 1'b0;
    end else if ((sz == DEPTH) && !dq && !f) m_full = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1;
    deq = 1'b0; flush = 1'b0; halt = 1'b0; mem_busy = 1'b0;
    ihit = 1'b1; imemload = $urandom;
    nRST = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_npc", npc_out, 32'd0);
    check("rst_imemaddr", imemaddr, PC_INIT);
    sb.delete();
    m_pc = PC_INIT; m_full = 1'b0; m_halted = 1'b0;
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    ihit = 1'b0;
  endtask

  task automatic rand_steps(input int n, input int halt_odds);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(15) == 0, $urandom & 32'h0000_FFFC,
           (halt_odds != 0) && ($urandom_range(halt_odds - 1) == 0),
           $urandom_range(3) == 0, $urandom_range(3) != 0, $urandom,
           $urandom_range(2) != 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    do_reset();

    // Fill from PC_INIT, then simultaneous enqueue/dequeue while full.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 1, $urandom, 1);

    // Flush at count 3 with a returning word.
    step(1, 32'h0000_0400, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Data-side stall.
    step(0, 0, 0, 0, 1, $urandom, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, $urandom, 0);
    step(0, 0, 0, 0, 1, $urandom, 0);

    // Halt with two entries, drain, redirect must not move the PC.
    step(0, 0, 1, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1, $urandom, 1);
    step(0, 0, 0, 0, 1, $urandom, 1);
    step(1, 32'h0000_0800, 0, 0, 1, $urandom, 0);
    step(0, 0, 0, 0, 1, $urandom, 0);

    // Empty queue, word returns with deq: visible only next cycle.
    do_reset();
    step(0, 0, 0, 0, 1, 32'h8C22_0004, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    rand_steps(3000, 0);
    do_reset();
    rand_steps(500, 0);
    rand_steps(300, 100);

    @(negedge CLK);
    #1;
    deq = 1'b0; ihit = 1'b0; flush = 1'b0;
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
